pipe_stage_chain: RTL and testbench

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage.sv | 39 +++
 rtl/pipe_stage_chain.sv | 85 ++++++++
 tb/tb_pipe_stage_chain.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared limits and the WIDTH/STAGES legality check for pipe_stage_chain.
package pipe_pkg;
    localparam int PIPE_MAX_STAGES = 8;
    localparam int PIPE_MAX_WIDTH  = 128;
    localparam int PIPE_MIN_STAGES = 2;

    function automatic bit pipe_params_ok(input int width, input int stages);
        return width >= 1 && width <= PIPE_MAX_WIDTH &&
               stages >= PIPE_MIN_STAGES && stages <= PIPE_MAX_STAGES;
    endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+data register of the chain with its ready term.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             flush,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // up_valid arrives already masked by the upstream stage's flush
    always_comb begin
        ready   = !flush && (!valid_q || dn_ready);
        valid_d = flush ? 1'b0 : ready ? up_valid : valid_q;
        data_d  = (ready && up_valid) ? up_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep valid/ready register chain with bubble collapse and per-stage flush.
// Optional occupancy output occ when PIPE_OCC_COUNT_EN is defined.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [STAGES-1:0] stage_valid
`ifdef PIPE_OCC_COUNT_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occ
`endif
);
    if (!pipe_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipe_stage_chain: WIDTH or STAGES out of range");
    end

    logic [STAGES-1:0]            vq;
    logic [STAGES-1:0][WIDTH-1:0] dq;

    // ready is chained through per-block signals so each stage's term is its own net
    for (genvar i = 0; i < STAGES; i++) begin : g_st
        logic             up_v, dn_rdy, rdy;
        logic [WIDTH-1:0] up_d;
        if (i == 0) begin : g_first
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_next
            assign up_v = vq[i-1] && !flush[i-1];
            assign up_d = dq[i-1];
        end
        if (i == STAGES - 1) begin : g_last
            assign dn_rdy = out_ready;
        end else begin : g_inner
            assign dn_rdy = g_st[i+1].rdy;
        end
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (Clk),
            .rst_n   (Rst),
            .up_valid(up_v),
            .up_data (up_d),
            .flush   (flush[i]),
            .dn_ready(dn_rdy),
            .valid   (vq[i]),
            .data    (dq[i]),
            .ready   (rdy)
        );
    end

    assign in_ready    = g_st[0].rdy;
    assign out_valid   = vq[STAGES-1] && !flush[STAGES-1];
    assign out_data    = dq[STAGES-1];
    assign stage_valid = vq;

`ifdef PIPE_OCC_COUNT_EN
    localparam int OW = $clog2(STAGES + 1);
    logic [STAGES-1:0] nv;
    logic [OW-1:0]     occ_d, occ_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_nv
        assign nv[i] = flush[i] ? 1'b0 : g_st[i].rdy ? g_st[i].up_v : vq[i];
    end

    always_comb begin
        occ_d = OW'($countones(nv));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end

    assign occ = occ_q;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed checks of pipe_stage_chain (WIDTH=32, STAGES=5);
// occ is also checked when PIPE_OCC_COUNT_EN is defined.
module tb_pipe_stage_chain;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [4:0]  flush = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [4:0]  stage_valid;
`ifdef PIPE_OCC_COUNT_EN
    logic [2:0]  occ;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] hold_exp [4] = '{32'h41, 32'h42, 32'h44, 32'h45};

    always #5 Clk = ~Clk;

    pipe_stage_chain #(.WIDTH(32), .STAGES(5)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .stage_valid(stage_valid)
`ifdef PIPE_OCC_COUNT_EN
        ,
        .occ        (occ)
`endif
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick;
        tick;
        check("rst_stage_valid", 32'(stage_valid), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
`ifdef PIPE_OCC_COUNT_EN
        check("rst_occ", 32'(occ), 32'h0);
`endif
        Rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // single item latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        #1;
        check("lat_in_ready", 32'(in_ready), 32'h1);
        tick;
        in_valid = 1'b0;
        in_data  = '0;
        for (int c = 1; c <= 5; c++) begin
            check("lat_out_valid", 32'(out_valid), 32'(c == 5));
            check("lat_in_ready_hold", 32'(in_ready), 32'h1);
            if (c < 5) tick;
        end
        check("lat_out_data", out_data, 32'h11);
        tick;
        check("lat_delivered", 32'(out_valid), 32'h0);

        // back-to-back stream
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_data  = 32'(c + 1);
            #1;
            check("stream_in_ready", 32'(in_ready), 32'h1);
            tick;
            check("stream_out_valid", 32'(out_valid), 32'(c + 1 >= 5 && c + 1 <= 12));
            if (c + 1 >= 5 && c + 1 <= 12) check("stream_out_data", out_data, 32'(c + 1 - 4));
        end
        in_valid = 1'b0;

        // backpressure fill and drain
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h21 + 32'(k);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h1);
            tick;
`ifdef PIPE_OCC_COUNT_EN
            check("bp_occ", 32'(occ), 32'(k + 1));
`endif
        end
        in_data = 32'h26;
        #1;
        check("bp_full_in_ready6", 32'(in_ready), 32'h0);
        tick;
        check("bp_full_stage_valid", 32'(stage_valid), 32'h1f);
        check("bp_full_out_valid", 32'(out_valid), 32'h1);
        check("bp_full_out_data", out_data, 32'h21);
        in_data = 32'h27;
        #1;
        check("bp_full_in_ready7", 32'(in_ready), 32'h0);
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_drain_valid", 32'(out_valid), 32'h1);
            check("bp_drain_data", out_data, 32'h21 + 32'(k));
            tick;
        end
        check("bp_drained_valid", 32'(out_valid), 32'h0);
        check("bp_drained_stages", 32'(stage_valid), 32'h0);
`ifdef PIPE_OCC_COUNT_EN
        check("bp_drained_occ", 32'(occ), 32'h0);
`endif

        // items in stages 0,2,4 then flush stage 2
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h31; tick;
        in_valid = 1'b0; tick;
        in_valid = 1'b1; in_data = 32'h32; tick;
        in_valid = 1'b0; tick;
        in_valid = 1'b1; in_data = 32'h33; tick;
        in_valid = 1'b0;
        check("fl_place", 32'(stage_valid), 32'h15);
        flush = 5'b00100;
        #1;
        check("fl_out_valid", 32'(out_valid), 32'h1);
        tick;
        flush = '0;
        check("fl_after", 32'(stage_valid), 32'h12);
        out_ready = 1'b1;
        #1;
        check("fl_first_valid", 32'(out_valid), 32'h1);
        check("fl_first_data", out_data, 32'h31);
        tick;
        check("fl_gap_stages", 32'(stage_valid), 32'h04);
        check("fl_gap_valid", 32'(out_valid), 32'h0);
        check("fl_data_kept", out_data, 32'h31);
        tick;
        check("fl_move", 32'(stage_valid), 32'h08);
        tick;
        check("fl_last_stages", 32'(stage_valid), 32'h10);
        check("fl_last_valid", 32'(out_valid), 32'h1);
        check("fl_last_data", out_data, 32'h33);
        tick;
        check("fl_done", 32'(out_valid), 32'h0);

        // full chain, flush stage 2: upstream stages hold one cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 32'h41 + 32'(k);
            tick;
        end
        in_valid = 1'b0;
        check("hold_full", 32'(stage_valid), 32'h1f);
        flush = 5'b00100;
        #1;
        check("hold_in_ready", 32'(in_ready), 32'h0);
        tick;
        flush = '0;
        check("hold_after_flush", 32'(stage_valid), 32'h1b);
        check("hold_out_data", out_data, 32'h41);
        tick;
        check("hold_shift", 32'(stage_valid), 32'h1e);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("hold_drain_valid", 32'(out_valid), 32'h1);
            check("hold_drain_data", out_data, hold_exp[k]);
            tick;
        end
        check("hold_drained", 32'(out_valid), 32'h0);

        // flush of last stage beats out_ready
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h51; tick;
        in_valid = 1'b0;
        repeat (4) tick;
        check("last_place", 32'(stage_valid), 32'h10);
        check("last_data", out_data, 32'h51);
        flush     = 5'b10000;
        out_ready = 1'b1;
        #1;
        check("last_masked", 32'(out_valid), 32'h0);
        tick;
        flush = '0;
        check("last_cleared", 32'(stage_valid), 32'h0);
        check("last_no_valid", 32'(out_valid), 32'h0);

        // reset mid-stream
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h61 + 32'(k);
            tick;
        end
        in_valid = 1'b0;
        check("mid_inflight", 32'(stage_valid), 32'h0f);
`ifdef PIPE_OCC_COUNT_EN
        check("mid_occ", 32'(occ), 32'h4);
`endif
        #2;
        Rst = 1'b0;
        #1;
        check("mid_rst_stages", 32'(stage_valid), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data", out_data, 32'h0);
`ifdef PIPE_OCC_COUNT_EN
        check("mid_rst_occ", 32'(occ), 32'h0);
`endif
        tick;
        Rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            check("post_rst_valid", 32'(out_valid), 32'h0);
            check("post_rst_stages", 32'(stage_valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
